midi_voice_dispatch: RTL and testbench
======================================

# midi_voice_dispatch

Front end of the synthesiser: parses a MIDI byte stream and generates the note event interface the synth core consumes (note_pressed/note_released, note, velocity, channel, addr). Incoming bytes arrive one at a time from the MIDI UART receiver. The block handles running status and real-time interleaving. It allocates a voice slot address for each sounding note and releases it on note-off or All-Notes-Off.

## Interface
- NUM_VOICES, 16: voice slots tracked; addr range 0..NUM_VOICES-1; legal 2..128.
- clk32  in  1  system clock (32 MHz).
- rst_n  in  1  asynchronous reset, active low.
- byte_in  in  8  received MIDI byte.
- byte_valid  in  1  byte_in valid; accepted on a clk32 edge when byte_valid && byte_ready.
- byte_ready  out  1  block can accept a byte; low only during flush.
- note_pressed  out  1  one-cycle pulse: start voice at addr.
- note_released  out  1  one-cycle pulse: release voice at addr.
- note  out  7  note number for the current pulse.
- velocity  out  7  on/off velocity for the current pulse; 0 for flush releases.
- channel  out  4  MIDI channel for the current pulse.
- addr  out  8  voice slot, zero-extended.
- voice_stolen  out  1  one-cycle pulse alongside note_pressed when a busy slot was reused for a different note.

## Operation
- Voice table: NUM_VOICES entries {active, channel[3:0], note[6:0]}. Round-robin steal pointer rr is log2(NUM_VOICES) bits.
- Parser states:
  - WAIT_STATUS: no running status; data bytes are discarded.
  - WAIT_D1: expecting the first data byte.
  - WAIT_D2: expecting the second data byte.
  - FLUSH: All-Notes-Off scan in progress.
- Status byte handling:
  - 0x8n / 0x9n: latch running status (type, channel n); go to WAIT_D1.
  - 0xAn, 0xBn, 0xEn: latch as a 2-data-byte message.
  - 0xCn, 0xDn: latch as a 1-data-byte message; D1 completes it.
  - 0xF0–0xF7: clear running status; go to WAIT_STATUS.
  - 0xF8–0xFF (real-time): accepted and ignored; state, running status and captured D1 are unchanged.
- Data byte handling:
  - Completion of D2 (or of D1 for 1-byte messages) returns to WAIT_D1 with running status kept.
  - A new status byte in WAIT_D1/WAIT_D2 aborts the partial message.
- Note-on (0x9n, vel≠0):
  1. If an active entry matches {n, note}, retrigger: note_pressed at that slot.
  2. Else, if any slot is inactive, use the lowest-index inactive slot.
  3. Else steal slot rr: note_pressed + voice_stolen, then rr ← (rr+1) mod NUM_VOICES.
  - The chosen entry is written active with {n, note}.
- Note-off (0x8n, or 0x9n with vel=0):
  - Matching active entry: note_released at that slot, entry cleared. velocity = release velocity; 0 for 0x9n vel 0.
  - No match: no pulse.
- Control change 0xBn with D1=0x78 or 0x7B (any D2): enter FLUSH.
  - Scan slots 0..NUM_VOICES-1, one per cycle.
  - Each active slot with channel n: emit note_released (velocity 0) and clear the entry.
  - After the last slot, return to WAIT_D1 with running status 0xBn.
- All other messages are parsed for length and otherwise ignored.

## Timing
- Reset (async assert, sync release) sets:
  - all pulses 0; note, velocity, channel, addr = 0;
  - byte_ready = 1;
  - table all inactive; rr = 0; state WAIT_STATUS.
- Event latency: the byte completing a message is accepted at edge N; the output pulse and table update are registered at edge N+1. Outputs are high for exactly one cycle.
- note, velocity, channel, addr are valid only while a pulse is high; otherwise they hold their last value.
- Pulse mutual exclusion: at most one of note_pressed/note_released is high per cycle.
- Back-to-back completing messages (possible only with bytes on consecutive cycles) give pulses on consecutive cycles. No event is dropped.
- FLUSH timing:
  - byte_ready goes low the cycle after the CC D2 is accepted.
  - FLUSH lasts exactly NUM_VOICES cycles; byte_ready returns high after the final slot is scanned.
  - Bytes presented during FLUSH are held by the source, not lost.
- Reset mid-flush or mid-message: everything returns to reset values; no pulse is emitted.

## Test plan
- 0x90 0x3C 0x64 → one cycle after the last byte: note_pressed=1, addr=0, note=0x3C, velocity=0x64, channel=0. Then 0x3E 0x50 (running status) → note_pressed, addr=1, note=0x3E.
- Continuing that sequence: 0x80 0x3C 0x40 → note_released, addr=0, velocity=0x40. Then 0x90 0x3E 0x00 → note_released, addr=1, velocity=0. Then 0x80 0x3C 0x40 again → no pulse.
- 17 distinct note-ons on channel 0 (NUM_VOICES=16) → addr 0..15 assigned in order. The 17th → addr=0 with voice_stolen=1. The 18th → addr=1 with voice_stolen=1.
- 0x91 0x40 0xF8 0x7F (real-time byte between data bytes) → note_pressed, channel=1, note=0x40, velocity=0x7F. Also: 0x91 0x40 0xF0 0x7F → no pulse.
- Setup: notes active on ch2 at slots 0 and 3, and on ch5 at slot 1. Stimulus: 0xB2 0x7B 0x00 → byte_ready low for 16 cycles; note_released at addr 0 then addr 3, velocity 0; slot 1 stays active.
- Assert rst_n low during a FLUSH → all outputs 0 immediately and byte_ready=1. A following 0x3C 0x64 data pair produces no pulse (running status cleared).

Source files
------------

// File: rtl/midi_voice_dispatch.sv
// midi_voice_dispatch
//   MIDI byte-stream parser and voice allocator for the synth core.
//   Parses running status, skips real-time bytes, tracks sounding notes in a
//   voice table and emits one-cycle note events with the slot address.
//
// Ports
//   clk32          system clock
//   rst_n          asynchronous active-low reset
//   byte_in        received MIDI byte
//   byte_valid     byte_in valid
//   byte_ready     block can take a byte (low only while flushing)
//   note_pressed   one-cycle pulse: start voice at addr
//   note_released  one-cycle pulse: release voice at addr
//   note           note number of the current pulse
//   velocity       velocity of the current pulse (0 for flush releases)
//   channel        MIDI channel of the current pulse
//   addr           voice slot, zero-extended
//   voice_stolen   one-cycle pulse with note_pressed when a busy slot is reused
//   state_dbg      parser state, for observation only
//
// Handshake: a byte transfers on a rising clk32 edge where byte_valid and
// byte_ready are both high; the source holds byte_in/byte_valid until then.
module midi_voice_dispatch #(
  parameter int NUM_VOICES = 16
) (
  input  logic       clk32,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       note_pressed,
  output logic       note_released,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic [3:0] channel,
  output logic [7:0] addr,
  output logic       voice_stolen,
  output logic [1:0] state_dbg
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic [1:0] S_WAIT_STATUS = 2'd0;
  localparam logic [1:0] S_WAIT_D1     = 2'd1;
  localparam logic [1:0] S_WAIT_D2     = 2'd2;
  localparam logic [1:0] S_FLUSH       = 2'd3;

  logic [1:0]            state;
  logic [3:0]            run_type;
  logic [3:0]            run_ch;
  logic [6:0]            d1;

  // A completed note message is staged here for one cycle; the table lookup
  // and the output pulse happen on the following edge.
  logic                  pend_valid;
  logic                  pend_on;
  logic [3:0]            pend_ch;
  logic [6:0]            pend_note;
  logic [6:0]            pend_vel;

  logic [NUM_VOICES-1:0] v_active;
  logic [3:0]            v_ch   [NUM_VOICES];
  logic [6:0]            v_note [NUM_VOICES];

  logic [IW-1:0]         rr;
  logic [IW-1:0]         rr_next;
  logic [IW-1:0]         flush_idx;

  logic                  accept;
  logic                  hit;
  logic [IW-1:0]         hit_idx;
  logic                  free;
  logic [IW-1:0]         free_idx;
  logic [IW-1:0]         on_idx;
  logic                  on_steal;

  assign byte_ready = (state != S_FLUSH);
  assign accept     = byte_valid && byte_ready;
  assign state_dbg  = state;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (v_active[i] && v_ch[i] == pend_ch && v_note[i] == pend_note) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!v_active[i]) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    on_steal = !hit && !free;
    on_idx   = hit ? hit_idx : (free ? free_idx : rr);
    rr_next  = (rr == IW'(NUM_VOICES - 1)) ? '0 : rr + 1'b1;
  end

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_WAIT_STATUS;
      run_type      <= '0;
      run_ch        <= '0;
      d1            <= '0;
      pend_valid    <= 1'b0;
      pend_on       <= 1'b0;
      pend_ch       <= '0;
      pend_note     <= '0;
      pend_vel      <= '0;
      v_active      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        v_ch[i]   <= '0;
        v_note[i] <= '0;
      end
      rr            <= '0;
      flush_idx     <= '0;
      note_pressed  <= 1'b0;
      note_released <= 1'b0;
      voice_stolen  <= 1'b0;
      note          <= '0;
      velocity      <= '0;
      channel       <= '0;
      addr          <= '0;
    end else begin
      note_pressed  <= 1'b0;
      note_released <= 1'b0;
      voice_stolen  <= 1'b0;
      pend_valid    <= 1'b0;

      // Staged note event. Never coincides with a flush scan cycle: the CC
      // that starts a flush needs two data bytes, so no note completes on
      // the edge just before the scan begins.
      if (pend_valid) begin
        if (pend_on) begin
          v_active[on_idx] <= 1'b1;
          v_ch[on_idx]     <= pend_ch;
          v_note[on_idx]   <= pend_note;
          note_pressed     <= 1'b1;
          voice_stolen     <= on_steal;
          note             <= pend_note;
          velocity         <= pend_vel;
          channel          <= pend_ch;
          addr             <= 8'(on_idx);
          if (on_steal) rr <= rr_next;
        end else if (hit) begin
          v_active[hit_idx] <= 1'b0;
          note_released     <= 1'b1;
          note              <= pend_note;
          velocity          <= pend_vel;
          channel           <= pend_ch;
          addr              <= 8'(hit_idx);
        end
      end

      // All-Notes-Off scan, one slot per cycle.
      if (state == S_FLUSH) begin
        if (v_active[flush_idx] && v_ch[flush_idx] == run_ch) begin
          v_active[flush_idx] <= 1'b0;
          note_released       <= 1'b1;
          note                <= v_note[flush_idx];
          velocity            <= '0;
          channel             <= run_ch;
          addr                <= 8'(flush_idx);
        end
        if (flush_idx == IW'(NUM_VOICES - 1)) state <= S_WAIT_D1;
        else                                   flush_idx <= flush_idx + 1'b1;
      end

      if (accept) begin
        if (byte_in[7]) begin
          if (byte_in[7:3] == 5'b11111) begin
            // real-time: no effect on parser state
          end else if (byte_in[7:4] == 4'hF) begin
            state <= S_WAIT_STATUS;
          end else begin
            run_type <= byte_in[7:4];
            run_ch   <= byte_in[3:0];
            state    <= S_WAIT_D1;
          end
        end else begin
          case (state)
            S_WAIT_D1: begin
              d1 <= byte_in[6:0];
              // Program change / channel pressure complete on D1.
              if (run_type == 4'hC || run_type == 4'hD) state <= S_WAIT_D1;
              else                                      state <= S_WAIT_D2;
            end
            S_WAIT_D2: begin
              state <= S_WAIT_D1;
              if (run_type == 4'h9 || run_type == 4'h8) begin
                pend_valid <= 1'b1;
                pend_on    <= (run_type == 4'h9) && (byte_in[6:0] != 7'd0);
                pend_ch    <= run_ch;
                pend_note  <= d1;
                pend_vel   <= byte_in[6:0];
              end else if (run_type == 4'hB && (d1 == 7'h78 || d1 == 7'h7B)) begin
                state     <= S_FLUSH;
                flush_idx <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_dispatch.sv
module tb_midi_voice_dispatch;

  logic       clk32;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       note_pressed;
  logic       note_released;
  logic [6:0] note;
  logic [6:0] velocity;
  logic [3:0] channel;
  logic [7:0] addr;
  logic       voice_stolen;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // {pressed, released, stolen, note, velocity, channel, addr}
  logic [28:0] exp_q[$];

  midi_voice_dispatch #(.NUM_VOICES(16)) dut (
    .clk32(clk32), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .note_pressed(note_pressed),
    .note_released(note_released), .note(note), .velocity(velocity),
    .channel(channel), .addr(addr), .voice_stolen(voice_stolen),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  function automatic logic [28:0] ev(input logic p, input logic r, input logic s,
                                     input logic [6:0] n, input logic [6:0] v,
                                     input logic [3:0] c, input logic [7:0] a);
    return {p, r, s, n, v, c, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk32);
    rst_n = 1'b1;
    @(negedge clk32);
  endtask

  // driver: hold the byte until it transfers
  task automatic send(input logic [7:0] b);
    int g;
    g = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && g < 100) begin
      @(posedge clk32); #1;
      g++;
    end
    if (g >= 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte 0x%0h not accepted", b);
    end
    @(posedge clk32); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk32);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // monitor / scoreboard
  always @(negedge clk32) begin
    if (rst_n && (note_pressed || note_released)) begin
      chk("pulse_exclusive", {31'd0, note_pressed && note_released}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got p=%0b r=%0b s=%0b note=0x%0h vel=0x%0h ch=%0d addr=%0d",
                 note_pressed, note_released, voice_stolen, note, velocity, channel, addr);
      end else begin
        chk("event", {3'd0, note_pressed, note_released, voice_stolen, note, velocity, channel, addr},
            {3'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin : stim
    int cnt;
    do_reset();

    // reset state
    chk("rst_pressed",  {31'd0, note_pressed}, 0);
    chk("rst_released", {31'd0, note_released}, 0);
    chk("rst_stolen",   {31'd0, voice_stolen}, 0);
    chk("rst_note",     {25'd0, note}, 0);
    chk("rst_velocity", {25'd0, velocity}, 0);
    chk("rst_channel",  {28'd0, channel}, 0);
    chk("rst_addr",     {24'd0, addr}, 0);
    chk("rst_ready",    {31'd0, byte_ready}, 1);
    chk("rst_state",    {30'd0, state_dbg}, 0);

    // basic on, running status, off, on-with-vel-0, unmatched off
    exp_q.push_back(ev(1, 0, 0, 7'h3C, 7'h64, 4'd0, 8'd0));
    send3(8'h90, 8'h3C, 8'h64);
    exp_q.push_back(ev(1, 0, 0, 7'h3E, 7'h50, 4'd0, 8'd1));
    send(8'h3E); send(8'h50);
    exp_q.push_back(ev(0, 1, 0, 7'h3C, 7'h40, 4'd0, 8'd0));
    send3(8'h80, 8'h3C, 8'h40);
    exp_q.push_back(ev(0, 1, 0, 7'h3E, 7'h00, 4'd0, 8'd1));
    send3(8'h90, 8'h3E, 8'h00);
    send3(8'h80, 8'h3C, 8'h40);
    drain("drain_basic");

    // allocation and stealing
    do_reset();
    send(8'h90);
    for (int i = 0; i < 18; i++) begin
      logic [6:0] n;
      n = 7'(8'h20 + i);
      if (i < 16) exp_q.push_back(ev(1, 0, 0, n, 7'h40, 4'd0, 8'(i)));
      else        exp_q.push_back(ev(1, 0, 1, n, 7'h40, 4'd0, 8'(i - 16)));
      send({1'b0, n}); send(8'h40);
    end
    // retrigger does not advance the steal pointer
    exp_q.push_back(ev(1, 0, 0, 7'h22, 7'h41, 4'd0, 8'd2));
    send(8'h22); send(8'h41);
    exp_q.push_back(ev(1, 0, 1, 7'h50, 7'h42, 4'd0, 8'd2));
    send(8'h50); send(8'h42);
    drain("drain_alloc");

    // real-time interleave, system byte abort
    do_reset();
    exp_q.push_back(ev(1, 0, 0, 7'h40, 7'h7F, 4'd1, 8'd0));
    send(8'h91); send(8'h40); send(8'hF8); send(8'h7F);
    send(8'h91); send(8'h40); send(8'hF0); send(8'h7F);
    drain("drain_realtime");

    // All-Notes-Off
    do_reset();
    exp_q.push_back(ev(1, 0, 0, 7'h30, 7'h40, 4'd2, 8'd0));
    send3(8'h92, 8'h30, 8'h40);
    exp_q.push_back(ev(1, 0, 0, 7'h31, 7'h40, 4'd5, 8'd1));
    send3(8'h95, 8'h31, 8'h40);
    exp_q.push_back(ev(1, 0, 0, 7'h32, 7'h40, 4'd7, 8'd2));
    send3(8'h97, 8'h32, 8'h40);
    exp_q.push_back(ev(1, 0, 0, 7'h33, 7'h40, 4'd2, 8'd3));
    send3(8'h92, 8'h33, 8'h40);
    exp_q.push_back(ev(0, 1, 0, 7'h30, 7'h00, 4'd2, 8'd0));
    exp_q.push_back(ev(0, 1, 0, 7'h33, 7'h00, 4'd2, 8'd3));
    send3(8'hB2, 8'h7B, 8'h00);
    chk("flush_ready_low", {31'd0, byte_ready}, 0);
    cnt = 0;
    while (!byte_ready && cnt < 100) begin
      @(posedge clk32); #1;
      cnt++;
    end
    chk("flush_len", cnt, 16);
    chk("flush_state_after", {30'd0, state_dbg}, 1);
    drain("drain_flush");
    // running status B2 kept: data-only CC flushes again (nothing left on ch2);
    // the next status byte is held by the source during the flush.
    send(8'h78); send(8'h00);
    exp_q.push_back(ev(0, 1, 0, 7'h31, 7'h22, 4'd5, 8'd1));
    send3(8'h85, 8'h31, 8'h22);
    drain("drain_flush2");

    // reset mid-flush
    do_reset();
    exp_q.push_back(ev(1, 0, 0, 7'h45, 7'h33, 4'd1, 8'd0));
    send3(8'h91, 8'h45, 8'h33);
    drain("drain_pre_flush");
    send3(8'hB0, 8'h78, 8'h00);
    repeat (5) @(posedge clk32);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pressed",  {31'd0, note_pressed}, 0);
    chk("mid_rst_released", {31'd0, note_released}, 0);
    chk("mid_rst_note",     {25'd0, note}, 0);
    chk("mid_rst_velocity", {25'd0, velocity}, 0);
    chk("mid_rst_channel",  {28'd0, channel}, 0);
    chk("mid_rst_addr",     {24'd0, addr}, 0);
    chk("mid_rst_ready",    {31'd0, byte_ready}, 1);
    chk("mid_rst_state",    {30'd0, state_dbg}, 0);
    @(negedge clk32);
    rst_n = 1'b1;
    @(negedge clk32);
    send(8'h3C); send(8'h64);
    send3(8'h81, 8'h45, 8'h33);
    drain("drain_post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
